// File: rtl/sampler_dma_voice_scheduler.sv
// Sampler DMA voice scheduler: per-voice burst descriptors feeding one round-robin
// arbiter that keeps a single burst outstanding on the memory fetch port.
module sampler_dma_voice_scheduler #(
  parameter int MAX_VOICES  = 64,
  parameter int BURST_BYTES = 64,
  parameter int VOICE_BITS  = (MAX_VOICES > 1) ? $clog2(MAX_VOICES) : 1
) (
  input  logic                  axi_clk,
  input  logic                  axi_reset,
  input  logic [31:0]           dma_control   [0:MAX_VOICES-1],
  input  logic [31:0]           dma_base_addr [0:MAX_VOICES-1],
  output logic [31:0]           dma_status    [0:MAX_VOICES-1],
  output logic [31:0]           dma_curr_addr [0:MAX_VOICES-1],
  input  logic [MAX_VOICES-1:0] voice_need,
  output logic                  fetch_valid,
  input  logic                  fetch_ready,
  output logic [31:0]           fetch_addr,
  output logic [VOICE_BITS-1:0] fetch_voice,
  input  logic                  fetch_done
);

  typedef enum logic [1:0] {V_IDLE = 2'd0, V_ACTIVE = 2'd1, V_DONE = 2'd2} vstate_t;
  typedef enum logic [1:0] {A_IDLE = 2'd0, A_REQ = 2'd1, A_WAIT = 2'd2} astate_t;

  vstate_t               r_vstate        [0:MAX_VOICES-1];
  vstate_t               w_vstate_nxt    [0:MAX_VOICES-1];
  logic [31:0]           r_curr_addr     [0:MAX_VOICES-1];
  logic [31:0]           w_curr_addr_nxt [0:MAX_VOICES-1];
  logic [15:0]           r_remaining     [0:MAX_VOICES-1];
  logic [15:0]           w_remaining_nxt [0:MAX_VOICES-1];
  logic [31:0]           r_status        [0:MAX_VOICES-1];

  astate_t               r_astate;
  astate_t               w_astate_nxt;
  logic [VOICE_BITS-1:0] r_grant;
  logic [VOICE_BITS-1:0] r_rr_ptr;
  logic [VOICE_BITS-1:0] w_pick;
  logic [VOICE_BITS-1:0] w_rr_nxt;
  logic                  w_found;
  logic                  w_done_evt;
  logic                  w_in_flight;
  logic [MAX_VOICES-1:0] w_elig;
  logic                  r_fetch_valid;
  logic [31:0]           r_fetch_addr;
  logic                  w_unused_ctrl;

  function automatic logic [31:0] f_status(input vstate_t st, input logic [15:0] rem);
    logic busy;
    logic done;
    busy = (st == V_ACTIVE);
    done = (st == V_DONE);
    return {rem, 14'd0, done, busy};
  endfunction

  assign fetch_valid   = r_fetch_valid;
  assign fetch_addr    = r_fetch_addr;
  assign fetch_voice   = r_grant;
  assign dma_status    = r_status;
  assign dma_curr_addr = r_curr_addr;

  // Control bits outside run and burst count are reserved.
  always_comb begin
    w_unused_ctrl = 1'b0;
    for (int v = 0; v < MAX_VOICES; v++) begin
      w_unused_ctrl = w_unused_ctrl ^ (^dma_control[v][31:24]) ^ (^dma_control[v][7:1]);
    end
  end

  // Voices that may compete for the next grant.
  always_comb begin
    w_elig = '0;
    for (int v = 0; v < MAX_VOICES; v++) begin
      w_elig[v] = (r_vstate[v] == V_ACTIVE) && dma_control[v][0] && voice_need[v];
    end
  end

  // Round-robin search upward from r_rr_ptr with wrap to voice 0.
  always_comb begin
    int k;
    logic [VOICE_BITS-1:0] idx;
    w_found = 1'b0;
    w_pick  = r_rr_ptr;
    k       = 0;
    idx     = '0;
    for (int i = 0; i < MAX_VOICES; i++) begin
      k = int'(r_rr_ptr) + i;
      if (k >= MAX_VOICES) begin
        k = k - MAX_VOICES;
      end else begin
        k = k;
      end
      idx = VOICE_BITS'(k);
      if (!w_found && w_elig[idx]) begin
        w_found = 1'b1;
        w_pick  = idx;
      end else begin
        w_found = w_found;
      end
    end
  end

  // Arbiter next state; fetch_done only counts while a burst is outstanding.
  always_comb begin
    w_astate_nxt = r_astate;
    w_done_evt   = 1'b0;
    w_in_flight  = (r_astate != A_IDLE);
    if (r_grant == VOICE_BITS'(MAX_VOICES - 1)) begin
      w_rr_nxt = '0;
    end else begin
      w_rr_nxt = r_grant + VOICE_BITS'(1);
    end
    case (r_astate)
      A_IDLE: begin
        if (w_found) begin
          w_astate_nxt = A_REQ;
        end else begin
          w_astate_nxt = A_IDLE;
        end
      end
      A_REQ: begin
        if (fetch_ready) begin
          w_astate_nxt = A_WAIT;
        end else begin
          w_astate_nxt = A_REQ;
        end
      end
      A_WAIT: begin
        if (fetch_done) begin
          w_astate_nxt = A_IDLE;
          w_done_evt   = 1'b1;
        end else begin
          w_astate_nxt = A_WAIT;
        end
      end
      default: w_astate_nxt = A_IDLE;
    endcase
  end

  // Arbiter registers; request fields latch at grant and hold until accepted.
  always_ff @(posedge axi_clk or negedge axi_reset) begin
    if (!axi_reset) begin
      r_astate      <= A_IDLE;
      r_grant       <= '0;
      r_rr_ptr      <= '0;
      r_fetch_valid <= 1'b0;
      r_fetch_addr  <= 32'd0;
    end else begin
      r_astate <= w_astate_nxt;
      if (r_astate == A_IDLE && w_found) begin
        r_grant       <= w_pick;
        r_fetch_addr  <= r_curr_addr[w_pick];
        r_fetch_valid <= 1'b1;
      end else if (r_astate == A_REQ && fetch_ready) begin
        r_fetch_valid <= 1'b0;
      end
      if (w_done_evt) begin
        r_rr_ptr <= w_rr_nxt;
      end
    end
  end

  // Per-voice descriptor state; a stopped voice waits out its in-flight burst.
  always_comb begin
    for (int v = 0; v < MAX_VOICES; v++) begin
      w_vstate_nxt[v]    = r_vstate[v];
      w_curr_addr_nxt[v] = r_curr_addr[v];
      w_remaining_nxt[v] = r_remaining[v];
      case (r_vstate[v])
        V_IDLE: begin
          if (dma_control[v][0]) begin
            w_curr_addr_nxt[v] = dma_base_addr[v];
            w_remaining_nxt[v] = dma_control[v][23:8];
            if (dma_control[v][23:8] != 16'd0) begin
              w_vstate_nxt[v] = V_ACTIVE;
            end else begin
              w_vstate_nxt[v] = V_DONE;
            end
          end else begin
            w_vstate_nxt[v] = V_IDLE;
          end
        end
        V_ACTIVE: begin
          if (w_done_evt && (r_grant == VOICE_BITS'(v))) begin
            w_curr_addr_nxt[v] = r_curr_addr[v] + 32'(BURST_BYTES);
            w_remaining_nxt[v] = r_remaining[v] - 16'd1;
            if (r_remaining[v] == 16'd1) begin
              w_vstate_nxt[v] = V_DONE;
            end else begin
              w_vstate_nxt[v] = V_ACTIVE;
            end
          end else if (!dma_control[v][0] && !(w_in_flight && (r_grant == VOICE_BITS'(v)))) begin
            w_vstate_nxt[v] = V_IDLE;
          end else begin
            w_vstate_nxt[v] = V_ACTIVE;
          end
        end
        V_DONE: begin
          if (!dma_control[v][0]) begin
            w_vstate_nxt[v] = V_IDLE;
          end else begin
            w_vstate_nxt[v] = V_DONE;
          end
        end
        default: w_vstate_nxt[v] = V_IDLE;
      endcase
    end
  end

  // Voice registers; status is registered alongside the state it reports.
  always_ff @(posedge axi_clk or negedge axi_reset) begin
    if (!axi_reset) begin
      for (int v = 0; v < MAX_VOICES; v++) begin
        r_vstate[v]    <= V_IDLE;
        r_curr_addr[v] <= 32'd0;
        r_remaining[v] <= 16'd0;
        r_status[v]    <= 32'd0;
      end
    end else begin
      for (int v = 0; v < MAX_VOICES; v++) begin
        r_vstate[v]    <= w_vstate_nxt[v];
        r_curr_addr[v] <= w_curr_addr_nxt[v];
        r_remaining[v] <= w_remaining_nxt[v];
        r_status[v]    <= f_status(w_vstate_nxt[v], w_remaining_nxt[v]);
      end
    end
  end

endmodule

// File: tb/tb_sampler_dma_voice_scheduler.sv
// Self-checking bench for sampler_dma_voice_scheduler: the bench acts as the memory
// read master and compares every grant and status against a transaction-level model.
module tb_sampler_dma_voice_scheduler;

  localparam int NV     = 64;
  localparam int VB     = 6;
  localparam int BB     = 64;
  localparam int M_IDLE = 0;
  localparam int M_ACT  = 1;
  localparam int M_DONE = 2;

  logic          clk;
  logic          axi_reset;
  logic [31:0]   dma_control   [0:NV-1];
  logic [31:0]   dma_base_addr [0:NV-1];
  logic [31:0]   dma_status    [0:NV-1];
  logic [31:0]   dma_curr_addr [0:NV-1];
  logic [NV-1:0] voice_need;
  logic          fetch_valid;
  logic          fetch_ready;
  logic [31:0]   fetch_addr;
  logic [VB-1:0] fetch_voice;
  logic          fetch_done;

  int n_checks = 0;
  int n_pass   = 0;
  int hs_cnt   = 0;
  int exp_hs   = 0;

  int          m_st   [0:NV-1];
  logic [31:0] m_addr [0:NV-1];
  int          m_rem  [0:NV-1];
  int          m_rr;
  int          got_v [$];
  logic [31:0] got_a [$];

  sampler_dma_voice_scheduler #(
    .MAX_VOICES(NV), .BURST_BYTES(BB), .VOICE_BITS(VB)
  ) dut (
    .axi_clk(clk), .axi_reset(axi_reset),
    .dma_control(dma_control), .dma_base_addr(dma_base_addr),
    .dma_status(dma_status), .dma_curr_addr(dma_curr_addr),
    .voice_need(voice_need),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_addr(fetch_addr), .fetch_voice(fetch_voice),
    .fetch_done(fetch_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (axi_reset && fetch_valid && fetch_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] m_status(input int v);
    if (m_st[v] == M_ACT)       return 32'(m_rem[v] << 16) | 32'h0000_0001;
    else if (m_st[v] == M_DONE) return 32'h0000_0002;
    else                        return 32'(m_rem[v] << 16);
  endfunction

  function automatic int model_pick();
    int k;
    for (int i = 0; i < NV; i++) begin
      k = (m_rr + i) % NV;
      if (m_st[k] == M_ACT && dma_control[k][0] && voice_need[k]) return k;
    end
    return -1;
  endfunction

  function automatic bit model_any_active();
    for (int i = 0; i < NV; i++) if (m_st[i] == M_ACT) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_st[i] = M_IDLE; m_addr[i] = 32'd0; m_rem[i] = 0;
    end
    m_rr = 0;
  endtask

  task automatic start_voice(input int v, input logic [31:0] base, input logic [15:0] n);
    logic [31:0] ctl;
    ctl       = $urandom;
    ctl[23:8] = n;
    ctl[0]    = 1'b1;
    dma_control[v]   = ctl;
    dma_base_addr[v] = base;
    m_addr[v] = base;
    m_rem[v]  = int'(n);
    m_st[v]   = (n != 16'd0) ? M_ACT : M_DONE;
  endtask

  task automatic apply_reset();
    axi_reset   = 1'b0;
    fetch_ready = 1'b0;
    fetch_done  = 1'b0;
    voice_need  = '0;
    for (int i = 0; i < NV; i++) begin
      dma_control[i] = 32'd0; dma_base_addr[i] = 32'd0;
    end
    model_reset();
    got_v.delete();
    got_a.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    int nz;
    nz = 0;
    for (int i = 0; i < NV; i++) if (dma_status[i] !== 32'd0 || dma_curr_addr[i] !== 32'd0) nz++;
    chk(tag, nz, 0);
  endtask

  task automatic quiet_check(input int n, input string tag);
    int cnt;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (fetch_valid !== 1'b0) cnt++;
    end
    chk(tag, cnt, 0);
  endtask

  // One full burst as the memory master: wait for a request, hold off ready,
  // accept, optionally change run/need while outstanding, then return done.
  task automatic do_burst(input int rdly, input int ddly, input bit stop_hs,
                          input bit chg_need, input logic [NV-1:0] nneed);
    int          v_exp;
    int          v;
    int          vv;
    int          wc;
    logic [31:0] a;
    logic [VB-1:0] vsel;
    v_exp = model_pick();
    wc = 0;
    while (fetch_valid !== 1'b1 && wc < 40) begin
      @(posedge clk); #1; wc++;
    end
    chk("grant_seen", fetch_valid, 1'b1);
    if (fetch_valid !== 1'b1) return;
    vsel = fetch_voice;
    v    = int'(fetch_voice);
    a    = fetch_addr;
    chk("grant_voice", v, v_exp);
    vv = (v_exp >= 0) ? v_exp : v;
    chk("grant_addr", a, m_addr[vv]);
    got_v.push_back(v);
    got_a.push_back(a);
    for (int i = 0; i < rdly; i++) begin
      @(posedge clk); #1;
      chk("req_hold", {fetch_valid, fetch_voice, fetch_addr}, {1'b1, vsel, a});
    end
    fetch_ready = 1'b1;
    @(posedge clk); #1;
    fetch_ready = 1'b0;
    exp_hs++;
    chk("valid_drop", fetch_valid, 1'b0);
    if (stop_hs) dma_control[vv][0] = 1'b0;
    if (chg_need) voice_need = nneed;
    for (int i = 0; i < ddly; i++) begin
      @(posedge clk); #1;
      chk("wait_quiet", fetch_valid, 1'b0);
    end
    fetch_done = 1'b1;
    @(posedge clk); #1;
    fetch_done = 1'b0;
    m_addr[vv] = m_addr[vv] + 32'(BB);
    m_rem[vv]  = m_rem[vv] - 1;
    m_rr       = (vv + 1) % NV;
    if (m_rem[vv] == 0) m_st[vv] = M_DONE;
    if (dma_control[vv][0] == 1'b0) m_st[vv] = M_IDLE;
    @(posedge clk); #1;
    chk("burst_status", dma_status[vv], m_status(vv));
    chk("burst_curr_addr", dma_curr_addr[vv], m_addr[vv]);
  endtask

  initial begin
    logic [31:0]   t1_exp [0:2];
    int            t2_exp [0:9];
    logic [NV-1:0] mask;
    int            sel [0:5];
    int            pick;
    int            wc;
    int            cnt2;

    apply_reset();
    chk("rst_valid", fetch_valid, 1'b0);
    chk("rst_voice", fetch_voice, 0);
    chk("rst_addr", fetch_addr, 32'd0);
    chk_all_zero("rst_regs");

    // Single voice, configured during reset so post-reset grant latency shows.
    start_voice(3, 32'h1000_0000, 16'd3);
    voice_need[3] = 1'b1;
    axi_reset = 1'b1;
    @(posedge clk); #1;
    chk("grant_lat_edge1", fetch_valid, 1'b0);
    @(posedge clk); #1;
    chk("grant_lat_edge2", fetch_valid, 1'b1);
    repeat (3) do_burst(0, 0, 1'b0, 1'b0, '0);
    t1_exp = '{32'h1000_0000, 32'h1000_0040, 32'h1000_0080};
    for (int i = 0; i < 3; i++) chk("single_addr_seq", got_a[i], t1_exp[i]);
    chk("single_status", dma_status[3], 32'h0000_0002);
    chk("single_curr", dma_curr_addr[3], 32'h1000_00C0);
    quiet_check(8, "single_no_more");
    chk("hs_count_single", hs_cnt, exp_hs);

    // Round robin over 0, 1, 5, then voice 1 loses need.
    apply_reset();
    start_voice(0, $urandom, 16'd8);
    start_voice(1, $urandom, 16'd8);
    start_voice(5, $urandom, 16'd8);
    voice_need = '0;
    voice_need[0] = 1'b1; voice_need[1] = 1'b1; voice_need[5] = 1'b1;
    axi_reset = 1'b1;
    mask = voice_need;
    mask[1] = 1'b0;
    repeat (5) do_burst($urandom_range(0, 2), $urandom_range(0, 2), 1'b0, 1'b0, '0);
    do_burst(0, 1, 1'b0, 1'b1, mask);
    repeat (4) do_burst($urandom_range(0, 2), $urandom_range(0, 2), 1'b0, 1'b0, '0);
    t2_exp = '{0, 1, 5, 0, 1, 5, 0, 5, 0, 5};
    for (int i = 0; i < 10; i++) chk("rr_order", got_v[i], t2_exp[i]);

    // Backpressure: ready withheld for 10 cycles.
    apply_reset();
    start_voice(20, 32'h2000_0100, 16'd2);
    voice_need[20] = 1'b1;
    axi_reset = 1'b1;
    do_burst(10, 3, 1'b0, 1'b0, '0);
    chk("hs_count_bp", hs_cnt, exp_hs);

    // Stop while the burst is outstanding; voice 7 keeps running.
    apply_reset();
    start_voice(2, 32'h3000_0000, 16'd5);
    start_voice(7, 32'h4000_0000, 16'd5);
    voice_need[2] = 1'b1; voice_need[7] = 1'b1;
    axi_reset = 1'b1;
    do_burst(1, 2, 1'b1, 1'b0, '0);
    chk("stop_status", dma_status[2], 32'h0004_0000);
    chk("stop_curr", dma_curr_addr[2], 32'h3000_0040);
    repeat (3) do_burst(0, 1, 1'b0, 1'b0, '0);
    cnt2 = 0;
    for (int i = 1; i < got_v.size(); i++) if (got_v[i] == 2) cnt2++;
    chk("stop_no_regrant", cnt2, 0);

    // Zero-length voice and address wrap.
    apply_reset();
    start_voice(9, 32'h5000_0000, 16'd0);
    start_voice(10, 32'hFFFF_FFC0, 16'd2);
    voice_need[9] = 1'b1; voice_need[10] = 1'b1;
    axi_reset = 1'b1;
    repeat (2) do_burst(0, 0, 1'b0, 1'b0, '0);
    chk("wrap_addr0", got_a[0], 32'hFFFF_FFC0);
    chk("wrap_addr1", got_a[1], 32'h0000_0000);
    chk("zero_n_status", dma_status[9], 32'h0000_0002);
    chk("wrap_status", dma_status[10], 32'h0000_0002);
    chk("wrap_curr", dma_curr_addr[10], 32'h0000_0040);
    quiet_check(6, "edges_no_more");

    // Randomised voices, delays and need changes against the model.
    apply_reset();
    mask = '0;
    for (int i = 0; i < 6; i++) begin
      pick = $urandom_range(0, NV - 1);
      while (mask[pick]) pick = $urandom_range(0, NV - 1);
      mask[pick] = 1'b1;
      sel[i] = pick;
      start_voice(pick, $urandom, 16'($urandom_range(1, 6)));
    end
    voice_need = mask;
    axi_reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      dma_base_addr[sel[i]] = $urandom;
      dma_control[sel[i]][23:8] = 16'($urandom_range(0, 9));
    end
    for (int it = 0; it < 60; it++) begin
      if (model_pick() < 0) begin
        if (!model_any_active()) break;
        quiet_check(4, "rnd_no_eligible");
        voice_need = mask;
      end
      do_burst($urandom_range(0, 3), $urandom_range(0, 3), 1'b0,
               ($urandom_range(0, 2) == 0), {$urandom, $urandom} & mask);
    end
    for (int i = 0; i < 6; i++) begin
      chk("rnd_final_status", dma_status[sel[i]], m_status(sel[i]));
      chk("rnd_final_curr", dma_curr_addr[sel[i]], m_addr[sel[i]]);
    end
    chk("hs_count_rnd", hs_cnt, exp_hs);

    // Asynchronous reset while a request is presented, then a stray done.
    apply_reset();
    start_voice(4, 32'h6000_0000, 16'd4);
    voice_need[4] = 1'b1;
    axi_reset = 1'b1;
    wc = 0;
    while (fetch_valid !== 1'b1 && wc < 20) begin
      @(posedge clk); #1; wc++;
    end
    chk("arst_req_seen", fetch_valid, 1'b1);
    #2;
    axi_reset = 1'b0;
    #1;
    chk("arst_valid", fetch_valid, 1'b0);
    chk("arst_voice", fetch_voice, 0);
    chk("arst_status", dma_status[4], 32'd0);
    chk("arst_curr", dma_curr_addr[4], 32'd0);
    apply_reset();
    axi_reset = 1'b1;
    @(posedge clk); #1;
    fetch_done = 1'b1;
    @(posedge clk); #1;
    fetch_done = 1'b0;
    quiet_check(6, "stray_done_quiet");
    chk_all_zero("stray_done_regs");
    chk("hs_count_final", hs_cnt, exp_hs);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sampler_dma_voice_scheduler.md
SAMPLER_DMA_VOICE_SCHEDULER -- requirements
Module: sampler_dma_voice_scheduler

Interface
REQ-001 Parameter MAX_VOICES, default 64, number of voice channels.
REQ-002 Parameter BURST_BYTES, default 64, bytes per fetch burst (power of two).
REQ-003 Parameter VOICE_BITS, default clog2(MAX_VOICES), voice index width.
REQ-004 Port axi_clk, input, 1, the only clock; all logic is rising-edge.
REQ-005 Port axi_reset, input, 1, asynchronous active-low reset.
REQ-006 Port dma_control, input, 32 x MAX_VOICES unpacked, per voice: bit0 = run, bits[23:8] = burst count N.
REQ-007 Port dma_base_addr, input, 32 x MAX_VOICES unpacked, per-voice sample start byte address.
REQ-008 Port dma_status, output, 32 x MAX_VOICES unpacked: bit0 = busy, bit1 = done, bits[31:16] = bursts remaining, other bits 0.
REQ-009 Port dma_curr_addr, output, 32 x MAX_VOICES unpacked, address of the next burst for each voice.
REQ-010 Port voice_need, input, MAX_VOICES, per-voice sample buffer below its refill threshold.
REQ-011 Port fetch_valid, output, 1, a burst request is presented.
REQ-012 Port fetch_ready, input, 1, the memory read master accepts the request.
REQ-013 Port fetch_addr, output, 32, burst start byte address.
REQ-014 Port fetch_voice, output, VOICE_BITS, voice that owns the burst.
REQ-015 Port fetch_done, input, 1, single-cycle pulse when the accepted burst has fully landed.

Function
REQ-016 Each voice has its own state machine: V_IDLE, V_ACTIVE, V_DONE.
REQ-017 V_IDLE -> V_ACTIVE when run is 1 and N != 0. On entry, curr_addr is loaded from dma_base_addr and remaining is loaded from N.
REQ-018 V_IDLE -> V_DONE when run is 1 and N == 0. No burst is issued.
REQ-019 V_ACTIVE -> V_IDLE when run is 0 and the voice has no burst in flight. If a burst is in flight, the transition happens in the cycle after fetch_done.
REQ-020 V_DONE -> V_IDLE when run is 0. Software must clear run and set it again to restart the voice.
REQ-021 Values of base_addr and N are sampled only on the V_IDLE exit. Later changes have no effect until the next start.
REQ-022 The arbiter state machine has three states: A_IDLE, A_REQ, A_WAIT.
REQ-023 In A_IDLE, an eligible voice is one that is in V_ACTIVE, has run = 1 and has voice_need = 1.
REQ-024 In A_IDLE, the arbiter grants the first eligible voice searching upward from rr_ptr, wrapping from MAX_VOICES-1 to 0. It then moves to A_REQ on the next edge.
REQ-025 In A_REQ, fetch_valid = 1, fetch_addr = curr_addr of the granted voice and fetch_voice = granted index. These outputs stay stable until fetch_ready is seen.
REQ-026 A handshake occurs when fetch_valid and fetch_ready are both 1 on an edge; the arbiter then moves to A_WAIT and fetch_valid drops.
REQ-027 Only one burst is ever in flight.
REQ-028 In A_WAIT, on fetch_done for the granted voice:
- curr_addr += BURST_BYTES, modulo 2^32 (wraps silently);
- remaining -= 1;
- rr_ptr = granted + 1, modulo MAX_VOICES;
- the arbiter returns to A_IDLE.
REQ-029 If remaining becomes 0 after the update, the voice enters V_DONE in the same edge.
REQ-030 fetch_done outside A_WAIT is ignored.
REQ-031 A granted request is never withdrawn. It completes even if run or voice_need drops while in A_REQ; the stop then takes effect per REQ-019.
REQ-032 Minimum spacing between grants is 2 cycles: A_WAIT -> A_IDLE -> A_REQ.
REQ-033 dma_status and dma_curr_addr are driven directly from registers, with no combinational path from inputs.
REQ-034 busy = 1 in V_ACTIVE. done = 1 in V_DONE. Both bits are 0 in V_IDLE.

Reset
REQ-035 Asynchronous assertion (axi_reset = 0) forces all of the following immediately, with no dependence on the clock:
- all voices to V_IDLE;
- the arbiter to A_IDLE;
- rr_ptr = 0;
- fetch_valid = 0, fetch_addr = 0, fetch_voice = 0;
- every dma_status and dma_curr_addr to 0.
REQ-036 Reset asserted mid-burst abandons the burst. After reset, a late fetch_done is ignored per REQ-030.
REQ-037 Deassertion is synchronised by the system. The first legal grant is 2 edges after deassertion.

Verification
REQ-038 Single voice: voice 3 with base 0x1000_0000, N = 3, run = 1, need = 1, ready and done always returned:
- required fetch_addr sequence: 0x1000_0000, 0x1000_0040, 0x1000_0080;
- then voice 3 is in V_DONE with status = 0x0000_0002 and curr_addr = 0x1000_00C0.
REQ-039 Round robin: voices 0, 1 and 5 active with need = 1 from reset:
- required grant order: 0, 1, 5, 0, 1, 5, ...;
- dropping need on voice 1 yields the order 0, 5, 0, 5.
REQ-040 Backpressure: fetch_ready held 0 for 10 cycles:
- fetch_valid, fetch_addr and fetch_voice are unchanged throughout;
- exactly one handshake occurs when ready rises.
REQ-041 Stop in flight: run of the granted voice cleared in A_WAIT:
- the burst completes;
- curr_addr advances once;
- the voice enters V_IDLE;
- no further grant goes to that voice.
REQ-042 Edges: N = 0 with run = 1 gives status 0x0000_0002 and no fetch. Base 0xFFFF_FFC0 with N = 2 gives fetch addresses 0xFFFF_FFC0 then 0x0000_0000.
REQ-043 Reset mid-burst: axi_reset pulsed low during A_REQ gives fetch_valid = 0 and all status = 0 asynchronously. A subsequent stray fetch_done causes no state change.
